pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//   Hazard/stall sequencer for the 5-stage pipeline. Decides each cycle whether PC and IF/ID
//   advance, whether ID/EX captures a bubble or freezes, and whether IF/ID is flushed.
//   Handles load-use hazards, taken-branch flushes (resolved in ID) and multi-cycle
//   data-memory waits. Keeps saturating stall/flush performance counters.
// PARAMETERS
//   REG_AW    5    register address width
//   CNT_W     16   width of stall_cnt_o / flush_cnt_o
//   WAIT_MAX  63   max consecutive MEM_WAIT cycles before err_o sets (>=1)
// PORTS
//   clk_i           in   1       clock, rising edge
//   rst_i           in   1       asynchronous active-high reset
//   start_i         in   1       pipeline enable; low forces IDLE
//   idex_memread_i  in   1       MemRead of the instruction now in ID/EX
//   idex_rd_i       in   REG_AW  RDaddr of the instruction now in ID/EX
//   ifid_rs1_i      in   REG_AW  RS1addr of the instruction now in ID
//   ifid_rs2_i      in   REG_AW  RS2addr of the instruction now in ID
//   branch_taken_i  in   1       branch in ID resolved taken this cycle
//   mem_busy_i      in   1       data memory not ready; pipeline must freeze
//   pc_write_o      out  1       PC may update
//   ifid_write_o    out  1       IF/ID may capture
//   ifid_flush_o    out  1       IF/ID loads NOP
//   idex_bubble_o   out  1       ID/EX captures zeroed control bits (RegWrite..ALUSrc)
//   idex_hold_o     out  1       ID/EX keeps its contents
//   stall_cnt_o     out  CNT_W  cycles with pc_write_o=0 while not IDLE, saturating
//   flush_cnt_o     out  CNT_W  taken-branch flushes, saturating
//   err_o           out  1       sticky: MEM_WAIT exceeded WAIT_MAX cycles
// BEHAVIOUR
//   States: IDLE, RUN, MEM_WAIT (2-bit register). Control outputs are combinational from
//   the state and the current inputs. Counters, err_o and wait_cnt are registered.
//   Reset: state=IDLE, wait_cnt=0, stall_cnt_o=0, flush_cnt_o=0, err_o=0.
//   IDLE: pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=1, idex_hold=0.
//     Goes to RUN on the next edge after start_i=1.
//   start_i=0 in any state: IDLE at the next edge. Counters and err_o are retained.
//   lu = idex_memread_i & (idex_rd_i!=0) & (idex_rd_i==ifid_rs1_i | idex_rd_i==ifid_rs2_i)
//   Priority in RUN (highest first):
//     1 mem_busy_i=1: pc_write=0, ifid_write=0, idex_hold=1, bubble=0, flush=0.
//       Next state is MEM_WAIT.
//     2 lu=1: pc_write=0, ifid_write=0, bubble=1, hold=0, flush=0.
//       branch_taken_i is ignored this cycle because its operands are not ready.
//       The bubble clears idex_memread, so the stall lasts exactly 1 cycle.
//     3 branch_taken_i=1: pc_write=1, ifid_write=1, flush=1, bubble=0.
//       flush_cnt_o increments.
//     4 otherwise: pc_write=1, ifid_write=1, others 0.
//   MEM_WAIT: same outputs as RUN case 1 while mem_busy_i=1, and wait_cnt increments.
//     mem_busy_i=0: outputs are evaluated as in RUN (cases 2-4) in that same cycle.
//       Next state is RUN and wait_cnt is cleared.
//     wait_cnt reaching WAIT_MAX sets err_o and stays in MEM_WAIT. The freeze is
//       never broken by the timeout.
//   Counter saturation: counters stick at all ones and do not wrap.
//   Reset mid-operation: all state and outputs return to reset values immediately.
//     The in-flight stall is abandoned.
// TESTING
//   Reset, start_i=1, no hazards: pc_write_o=1 from the 2nd cycle on; counters stay 0.
//   idex_memread=1, idex_rd=5, ifid_rs2=5: exactly 1 cycle of pc_write=0 and
//     bubble=1; stall_cnt=1.
//   Same as above but idex_rd=0: no stall.
//   lu and branch_taken_i in the same cycle: stall only, flush=0, flush_cnt unchanged.
//   mem_busy_i high for 3 cycles: hold=1 for 3 cycles; stall_cnt=3; next cycle is RUN.
//   WAIT_MAX=4, mem_busy held for 10 cycles: err_o=1 after the 4th wait cycle and
//     stays high; rst_i pulse clears err_o.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall sequencer for a 5-stage pipeline: load-use bubbles, taken-branch
// flushes resolved in ID, and data-memory wait freezes, plus saturating perf counters.
module pipe_hazard_ctrl #(
   parameter int REG_AW   = 5,
   parameter int CNT_W    = 16,
   parameter int WAIT_MAX = 63
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              idex_memread_i,
   input  logic [REG_AW-1:0] idex_rd_i,
   input  logic [REG_AW-1:0] ifid_rs1_i,
   input  logic [REG_AW-1:0] ifid_rs2_i,
   input  logic              branch_taken_i,
   input  logic              mem_busy_i,
   output logic              pc_write_o,
   output logic              ifid_write_o,
   output logic              ifid_flush_o,
   output logic              idex_bubble_o,
   output logic              idex_hold_o,
   output logic [CNT_W-1:0]  stall_cnt_o,
   output logic [CNT_W-1:0]  flush_cnt_o,
   output logic              err_o
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      MEM_WAIT = 2'd2
   } state_e;

   localparam int             WCW  = $clog2(WAIT_MAX + 1);
   localparam logic [WCW-1:0] WMAX = WCW'(WAIT_MAX);

   state_e             state_q, state_d;
   logic [WCW-1:0]     wait_q, wait_d;
   logic [CNT_W-1:0]   stall_q, stall_d;
   logic [CNT_W-1:0]   flush_q, flush_d;
   logic               err_q, err_d;
   logic               lu;
   logic               pc_w, ifid_w, flush, bubble, hold;

   assign lu = idex_memread_i && (idex_rd_i != '0) &&
               ((idex_rd_i == ifid_rs1_i) || (idex_rd_i == ifid_rs2_i));

   always_comb begin
      pc_w    = 1'b0;
      ifid_w  = 1'b0;
      flush   = 1'b0;
      bubble  = 1'b0;
      hold    = 1'b0;
      state_d = state_q;
      wait_d  = '0;
      stall_d = stall_q;
      flush_d = flush_q;
      err_d   = err_q;

      case (state_q)
         IDLE: begin
            bubble  = 1'b1;
            state_d = RUN;
         end
         RUN, MEM_WAIT: begin
            if (mem_busy_i) begin
               hold    = 1'b1;
               state_d = MEM_WAIT;
               if (state_q == MEM_WAIT) begin
                  wait_d = (wait_q == WMAX) ? wait_q : wait_q + 1'b1;
                  // Timeout only flags the condition; the freeze continues.
                  if (wait_d == WMAX) err_d = 1'b1;
               end
            end else begin
               state_d = RUN;
               if (lu) begin
                  // Branch operands depend on the load, so a taken branch waits too.
                  bubble = 1'b1;
               end else begin
                  pc_w   = 1'b1;
                  ifid_w = 1'b1;
                  flush  = branch_taken_i;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (!start_i) state_d = IDLE;

      if ((state_q != IDLE) && !pc_w && (stall_q != '1)) stall_d = stall_q + 1'b1;
      if (flush && (flush_q != '1)) flush_d = flush_q + 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         wait_q  <= '0;
         stall_q <= '0;
         flush_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         stall_q <= stall_d;
         flush_q <= flush_d;
         err_q   <= err_d;
      end
   end

   assign pc_write_o    = pc_w;
   assign ifid_write_o  = ifid_w;
   assign ifid_flush_o  = flush;
   assign idex_bubble_o = bubble;
   assign idex_hold_o   = hold;
   assign stall_cnt_o   = stall_q;
   assign flush_cnt_o   = flush_q;
   assign err_o         = err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

   localparam int CNT_W = 4;
   localparam int WMAX  = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst, start, memread, br, busy;
   logic [4:0]       rd, rs1, rs2;
   logic             pc_w, ifid_w, flush, bubble, hold, err;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;
   logic [4:0]       ctl;

   int checks = 0;
   int errors = 0;

   // model state: mode 0=idle 1=run 2=waiting
   int m_mode, m_wait, m_stall, m_flush;
   bit m_err;

   pipe_hazard_ctrl #(.REG_AW(5), .CNT_W(CNT_W), .WAIT_MAX(WMAX)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start),
      .idex_memread_i(memread), .idex_rd_i(rd),
      .ifid_rs1_i(rs1), .ifid_rs2_i(rs2),
      .branch_taken_i(br), .mem_busy_i(busy),
      .pc_write_o(pc_w), .ifid_write_o(ifid_w), .ifid_flush_o(flush),
      .idex_bubble_o(bubble), .idex_hold_o(hold),
      .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt), .err_o(err)
   );

   always #5 clk = ~clk;
   assign ctl = {pc_w, ifid_w, flush, bubble, hold};

   // {pc_write, ifid_write, flush, bubble, hold}
   function automatic logic [4:0] exp_ctrl();
      logic lu;
      lu = memread && (rd != 0) && (rd == rs1 || rd == rs2);
      if (m_mode == 0) return 5'b00010;
      if (busy)        return 5'b00001;
      if (lu)          return 5'b00010;
      if (br)          return 5'b11100;
      return 5'b11000;
   endfunction

   task automatic model_edge();
      logic [4:0] c;
      c = exp_ctrl();
      if (m_mode != 0 && !c[4] && m_stall < CMAX) m_stall++;
      if (c[2] && m_flush < CMAX) m_flush++;
      if (m_mode == 2 && busy) begin
         if (m_wait < WMAX) m_wait++;
         if (m_wait == WMAX) m_err = 1;
      end else m_wait = 0;
      if (!start)           m_mode = 0;
      else if (m_mode == 0) m_mode = 1;
      else                  m_mode = busy ? 2 : 1;
   endtask

   task automatic drive(input logic s, input logic mr, input logic [4:0] d,
                        input logic [4:0] r1, input logic [4:0] r2,
                        input logic b, input logic bz);
      start = s; memread = mr; rd = d; rs1 = r1; rs2 = r2; br = b; busy = bz;
      #1;
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      m_mode = 0; m_wait = 0; m_stall = 0; m_flush = 0; m_err = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic go_run();
      drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      if (ctl !== 5'b00010) begin errors++; $display("FAIL reset_ctl got %b exp 00010", ctl); end
      checks++;
      if (stall_cnt !== 0 || flush_cnt !== 0 || err !== 1'b0) begin
         errors++; $display("FAIL reset_regs got stall=%0d flush=%0d err=%b exp 0 0 0", stall_cnt, flush_cnt, err);
      end
      checks++;
   endtask

   task automatic test_no_hazard();
      do_reset();
      drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      if (pc_w !== 1'b0) begin errors++; $display("FAIL nohaz_first got pc=%b exp 0", pc_w); end
      checks++;
      tick();
      for (int i = 0; i < 5; i++) begin
         if (ctl !== 5'b11000) begin errors++; $display("FAIL nohaz_run%0d got %b exp 11000", i, ctl); end
         checks++;
         tick();
      end
      if (stall_cnt !== 0 || flush_cnt !== 0) begin
         errors++; $display("FAIL nohaz_cnt got stall=%0d flush=%0d exp 0 0", stall_cnt, flush_cnt);
      end
      checks++;
   endtask

   task automatic test_load_use();
      do_reset(); go_run();
      drive(1'b1, 1'b1, 5'd5, 5'd3, 5'd5, 1'b0, 1'b0);
      if (ctl !== 5'b00010) begin errors++; $display("FAIL lu_stall got %b exp 00010", ctl); end
      checks++;
      tick();
      drive(1'b1, 1'b0, 5'd0, 5'd3, 5'd5, 1'b0, 1'b0);
      if (ctl !== 5'b11000 || stall_cnt !== 1) begin
         errors++; $display("FAIL lu_after got ctl=%b stall=%0d exp 11000 1", ctl, stall_cnt);
      end
      checks++;
      tick();
      // rd = 0 never creates a hazard
      drive(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      if (ctl !== 5'b11000) begin errors++; $display("FAIL lu_rd0 got %b exp 11000", ctl); end
      checks++;
      tick();
      if (stall_cnt !== 1) begin errors++; $display("FAIL lu_rd0_cnt got %0d exp 1", stall_cnt); end
      checks++;
   endtask

   task automatic test_branch();
      do_reset(); go_run();
      drive(1'b1, 1'b1, 5'd7, 5'd7, 5'd1, 1'b1, 1'b0);
      if (ctl !== 5'b00010) begin errors++; $display("FAIL lu_br got %b exp 00010", ctl); end
      checks++;
      tick();
      if (flush_cnt !== 0 || stall_cnt !== 1) begin
         errors++; $display("FAIL lu_br_cnt got flush=%0d stall=%0d exp 0 1", flush_cnt, stall_cnt);
      end
      checks++;
      drive(1'b1, 1'b0, 5'd7, 5'd7, 5'd1, 1'b1, 1'b0);
      if (ctl !== 5'b11100) begin errors++; $display("FAIL br_flush got %b exp 11100", ctl); end
      checks++;
      tick();
      if (flush_cnt !== 1) begin errors++; $display("FAIL br_cnt got %0d exp 1", flush_cnt); end
      checks++;
   endtask

   task automatic test_mem_busy();
      do_reset(); go_run();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 5'd2, 5'd2, 5'd2, 1'b1, 1'b1);
         if (ctl !== 5'b00001) begin errors++; $display("FAIL busy_hold%0d got %b exp 00001", i, ctl); end
         checks++;
         tick();
      end
      drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      if (ctl !== 5'b11000 || stall_cnt !== 3) begin
         errors++; $display("FAIL busy_exit got ctl=%b stall=%0d exp 11000 3", ctl, stall_cnt);
      end
      checks++;
      tick();
      if (ctl !== 5'b11000 || err !== 1'b0) begin
         errors++; $display("FAIL busy_run got ctl=%b err=%b exp 11000 0", ctl, err);
      end
      checks++;
   endtask

   task automatic test_timeout();
      do_reset(); go_run();
      // cycle 1 is in RUN; wait cycles 2..5 bring the count to WAIT_MAX
      for (int k = 1; k <= 10; k++) begin
         drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
         if (hold !== 1'b1 || pc_w !== 1'b0) begin
            errors++; $display("FAIL tmo_hold%0d got hold=%b pc=%b exp 1 0", k, hold, pc_w);
         end
         checks++;
         tick();
         if (err !== (k >= 5)) begin
            errors++; $display("FAIL tmo_err%0d got %b exp %b", k, err, (k >= 5));
         end
         checks++;
      end
      drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      tick();
      if (err !== 1'b1) begin errors++; $display("FAIL tmo_sticky got %b exp 1", err); end
      checks++;
      rst = 1'b1;
      #1;
      if (err !== 1'b0) begin errors++; $display("FAIL tmo_clear got %b exp 0", err); end
      checks++;
      do_reset();
   endtask

   task automatic test_reset_mid();
      do_reset(); go_run();
      drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
      tick();
      tick();
      #2 rst = 1'b1;
      #1;
      if (ctl !== 5'b00010 || stall_cnt !== 0) begin
         errors++; $display("FAIL rstmid got ctl=%b stall=%0d exp 00010 0", ctl, stall_cnt);
      end
      checks++;
      do_reset();
   endtask

   task automatic test_start_low();
      do_reset(); go_run();
      drive(1'b1, 1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0);
      tick();
      drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
      tick();
      tick();
      tick();
      if (ctl !== 5'b00010 || stall_cnt !== 1 || flush_cnt !== 1) begin
         errors++; $display("FAIL startlow got ctl=%b stall=%0d flush=%0d exp 00010 1 1", ctl, stall_cnt, flush_cnt);
      end
      checks++;
   endtask

   task automatic test_saturation();
      do_reset(); go_run();
      drive(1'b1, 1'b1, 5'd9, 5'd9, 5'd9, 1'b0, 1'b0);
      repeat (CMAX + 5) tick();
      drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
      repeat (CMAX + 5) tick();
      if (stall_cnt !== CNT_W'(CMAX) || flush_cnt !== CNT_W'(CMAX)) begin
         errors++; $display("FAIL sat got stall=%0d flush=%0d exp %0d %0d", stall_cnt, flush_cnt, CMAX, CMAX);
      end
      checks++;
   endtask

   task automatic test_random();
      logic [4:0] e;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 15) != 0), $urandom_range(0, 1), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
         e = exp_ctrl();
         if (ctl !== e) begin errors++; $display("FAIL rnd_ctl%0d got %b exp %b", i, ctl, e); end
         checks++;
         tick();
         if (stall_cnt !== CNT_W'(m_stall) || flush_cnt !== CNT_W'(m_flush) || err !== m_err) begin
            errors++;
            $display("FAIL rnd_regs%0d got stall=%0d flush=%0d err=%b exp %0d %0d %b",
                     i, stall_cnt, flush_cnt, err, m_stall, m_flush, m_err);
         end
         checks++;
      end
   endtask

   initial begin
      test_reset();
      test_no_hazard();
      test_load_use();
      test_branch();
      test_mem_busy();
      test_timeout();
      test_reset_mid();
      test_start_low();
      test_saturation();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
